// File: rtl/sequence_search_coordinator.sv
// rtl/sequence_search_coordinator.sv - sweeps generator sequence lengths and tallies comparator hits
//
// Purpose: for each length from MIN_LENGTH up to a host limit, pulse the
// generator start, wait for its completion edge, let the multiplier/comparator
// pipeline drain, and count hits. Reports the first length with a hit, the
// saturating hit total and done/error/aborted status to the host.
//
// Ports:
//   clk, reset          clock, synchronous active-low reset
//   run, abort          host start pulse / abort request
//   stop_on_hit         end the sweep after the first length with a hit
//   length_limit        last length to sweep (sampled with run)
//   busy, done          sweep in progress / one-cycle end pulse
//   error, aborted      last run rejected / last sweep aborted
//   found, found_length first hit flag and its length
//   total_hits          saturating hit count over the sweep
//   gen_max_length      length presented to the generator
//   gen_start           generator start pulse
//   gen_complete        generator completion level
//   match_valid/hit     comparator result strobe and result
module sequence_search_coordinator #(
  parameter int SEQ_INDEX_BITS   = 5,
  parameter int MIN_LENGTH       = 1,
  parameter int MAX_LENGTH_LIMIT = 5,
  parameter int DRAIN_CYCLES     = 8,
  parameter int HIT_BITS         = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      run,
  input  logic                      abort,
  input  logic                      stop_on_hit,
  input  logic [SEQ_INDEX_BITS-1:0] length_limit,
  output logic                      busy,
  output logic                      done,
  output logic                      error,
  output logic                      aborted,
  output logic                      found,
  output logic [SEQ_INDEX_BITS-1:0] found_length,
  output logic [HIT_BITS-1:0]       total_hits,
  output logic [SEQ_INDEX_BITS-1:0] gen_max_length,
  output logic                      gen_start,
  input  logic                      gen_complete,
  input  logic                      match_valid,
  input  logic                      match_hit
);

  localparam int DRAIN_BITS = $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LAUNCH, S_RUNNING, S_DRAIN, S_FINISH, S_ABORTING
  } state_t;

  state_t                    state_q, state_d;
  logic [SEQ_INDEX_BITS-1:0] cur_len_q, cur_len_d;
  logic [SEQ_INDEX_BITS-1:0] lim_q, lim_d;
  logic                      stop_q, stop_d;
  logic [HIT_BITS-1:0]       len_hits_q, len_hits_d;
  logic [HIT_BITS-1:0]       total_hits_q, total_hits_d;
  logic [DRAIN_BITS-1:0]     drain_q, drain_d;
  logic                      gc_prev_q;
  logic                      found_q, found_d;
  logic [SEQ_INDEX_BITS-1:0] found_len_q, found_len_d;
  logic                      error_q, error_d;
  logic                      aborted_q, aborted_d;
  logic                      done_q, done_d;

  logic gc_rise;
  logic count_en;
  logic found_now;
  logic limit_ok;

  // Only a fresh edge counts: a level left high from the previous length is ignored.
  assign gc_rise  = gen_complete & ~gc_prev_q;
  assign count_en = match_valid & match_hit &
                    ((state_q == S_RUNNING) || (state_q == S_DRAIN));
  assign limit_ok = (length_limit >= SEQ_INDEX_BITS'(MIN_LENGTH)) &&
                    (length_limit <= SEQ_INDEX_BITS'(MAX_LENGTH_LIMIT));

  always_comb begin
    state_d      = state_q;
    cur_len_d    = cur_len_q;
    lim_d        = lim_q;
    stop_d       = stop_q;
    len_hits_d   = len_hits_q;
    total_hits_d = total_hits_q;
    drain_d      = drain_q;
    found_d      = found_q;
    found_len_d  = found_len_q;
    error_d      = error_q;
    aborted_d    = aborted_q;
    done_d       = 1'b0;
    found_now    = 1'b0;

    // Counted before any evaluation in the same cycle.
    if (count_en) begin
      if (len_hits_q != '1)   len_hits_d   = len_hits_q + 1'b1;
      if (total_hits_q != '1) total_hits_d = total_hits_q + 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          if (limit_ok) begin
            lim_d        = length_limit;
            stop_d       = stop_on_hit;
            found_d      = 1'b0;
            found_len_d  = '0;
            total_hits_d = '0;
            error_d      = 1'b0;
            aborted_d    = 1'b0;
            cur_len_d    = SEQ_INDEX_BITS'(MIN_LENGTH);
            state_d      = S_LAUNCH;
          end else begin
            error_d = 1'b1;
            done_d  = 1'b1;
          end
        end
      end
      S_LAUNCH: begin
        len_hits_d = '0;
        state_d    = abort ? S_ABORTING : S_RUNNING;
      end
      S_RUNNING: begin
        if (abort) begin
          state_d = S_ABORTING;
        end else if (gc_rise) begin
          drain_d = DRAIN_BITS'(DRAIN_CYCLES);
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (abort) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end else if (drain_q == '0) begin
          found_now = found_q | (len_hits_d != '0);
          if ((len_hits_d != '0) && !found_q) begin
            found_d     = 1'b1;
            found_len_d = cur_len_q;
          end
          if (stop_q && found_now) begin
            state_d = S_FINISH;
          end else if (cur_len_q == lim_q) begin
            state_d = S_FINISH;
          end else begin
            cur_len_d = cur_len_q + 1'b1;
            state_d   = S_LAUNCH;
          end
        end else begin
          drain_d = drain_q - 1'b1;
        end
      end
      S_ABORTING: begin
        // Hold off until the generator is back waiting before finishing.
        if (gc_rise) begin
          aborted_d = 1'b1;
          state_d   = S_FINISH;
        end
      end
      S_FINISH: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      cur_len_q    <= '0;
      lim_q        <= '0;
      stop_q       <= 1'b0;
      len_hits_q   <= '0;
      total_hits_q <= '0;
      drain_q      <= '0;
      gc_prev_q    <= 1'b0;
      found_q      <= 1'b0;
      found_len_q  <= '0;
      error_q      <= 1'b0;
      aborted_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      cur_len_q    <= cur_len_d;
      lim_q        <= lim_d;
      stop_q       <= stop_d;
      len_hits_q   <= len_hits_d;
      total_hits_q <= total_hits_d;
      drain_q      <= drain_d;
      gc_prev_q    <= gen_complete;
      found_q      <= found_d;
      found_len_q  <= found_len_d;
      error_q      <= error_d;
      aborted_q    <= aborted_d;
      done_q       <= done_d;
    end
  end

  assign busy           = (state_q != S_IDLE);
  assign gen_start      = (state_q == S_LAUNCH);
  assign gen_max_length = cur_len_q;
  assign done           = done_q;
  assign error          = error_q;
  assign aborted        = aborted_q;
  assign found          = found_q;
  assign found_length   = found_len_q;
  assign total_hits     = total_hits_q;

endmodule

// File: tb/tb_sequence_search_coordinator.sv
// tb/tb_sequence_search_coordinator.sv - directed self-checking bench for sequence_search_coordinator
module tb_sequence_search_coordinator;

  logic        clk = 1'b0;
  logic        reset;
  logic        run, abort, stop_on_hit;
  logic [4:0]  length_limit;
  logic        busy, done, error, aborted, found;
  logic [4:0]  found_length, gen_max_length;
  logic [15:0] total_hits;
  logic        gen_start, gen_complete, match_valid, match_hit;
  logic        mv_model, mh_model, mv_man, mh_man;

  assign match_valid = mv_model | mv_man;
  assign match_hit   = mh_model | mh_man;

  always #5 clk = ~clk;

  sequence_search_coordinator dut (
    .clk(clk), .reset(reset), .run(run), .abort(abort),
    .stop_on_hit(stop_on_hit), .length_limit(length_limit),
    .busy(busy), .done(done), .error(error), .aborted(aborted),
    .found(found), .found_length(found_length), .total_hits(total_hits),
    .gen_max_length(gen_max_length), .gen_start(gen_start),
    .gen_complete(gen_complete), .match_valid(match_valid), .match_hit(match_hit)
  );

  int n_checks = 0;
  int n_errors = 0;
  int done_cnt;
  bit busy_seen;
  logic [3:0] hit_plan [0:31];
  int start_cnt;
  int start_len [0:15];
  int start_cyc [0:15];
  int cyc;
  int cnt;
  int hits_left;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (done) done_cnt++;
    if (busy) busy_seen = 1'b1;
  endtask

  // Generator + comparator model: completion 10 cycles after each start,
  // planned hits and one non-hit strobe per length while running.
  initial begin
    gen_complete = 1'b0; mv_model = 1'b0; mh_model = 1'b0;
    cnt = 0; hits_left = 0; cyc = 0; start_cnt = 0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      mv_model = 1'b0;
      mh_model = 1'b0;
      if (gen_start) begin
        gen_complete = 1'b0;
        cnt = 10;
        hits_left = int'(hit_plan[gen_max_length]);
        if (start_cnt < 16) begin
          start_len[start_cnt] = int'(gen_max_length);
          start_cyc[start_cnt] = cyc;
        end
        start_cnt++;
      end else if (cnt > 0) begin
        cnt--;
        if (cnt == 0) gen_complete = 1'b1;
        if (hits_left > 0 && cnt <= 8 && cnt > 0) begin
          mv_model = 1'b1; mh_model = 1'b1; hits_left--;
        end else if (cnt == 3) begin
          mv_model = 1'b1;
        end
      end
    end
  end

  task automatic run_sweep(input logic [4:0] lim, input logic stop, output bit ok);
    ok = 1'b0;
    done_cnt = 0;
    busy_seen = 1'b0;
    length_limit = lim;
    stop_on_hit = stop;
    run = 1'b1;
    for (int i = 0; i < 2000 && !ok; i++) begin
      tick();
      run = 1'b0;
      if (done) ok = 1'b1;
    end
    repeat (3) tick();
  endtask

  initial begin
    bit ok;
    bit seen;
    bit early_drop;
    int base;
    int n;
    reset = 1'b0; run = 1'b0; abort = 1'b0; stop_on_hit = 1'b0;
    length_limit = '0; mv_man = 1'b0; mh_man = 1'b0;
    for (int i = 0; i < 32; i++) hit_plan[i] = '0;
    done_cnt = 0; busy_seen = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    tick();
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_error", error, 0);
    check("rst_found", found, 0);
    check("rst_total", total_hits, 0);
    check("rst_gen_start", gen_start, 0);
    check("rst_gen_len", gen_max_length, 0);

    // Illegal limits
    base = start_cnt;
    run_sweep(5'd0, 1'b0, ok);
    check("err0_done_seen", ok, 1);
    check("err0_done_once", done_cnt, 1);
    check("err0_error", error, 1);
    check("err0_busy_never", busy_seen, 0);
    check("err0_no_start", start_cnt - base, 0);
    run_sweep(5'd6, 1'b0, ok);
    check("err6_error", error, 1);
    check("err6_busy_never", busy_seen, 0);

    // Plain sweep 1..3, no hits
    base = start_cnt;
    run_sweep(5'd3, 1'b0, ok);
    check("sw3_done_seen", ok, 1);
    check("sw3_done_once", done_cnt, 1);
    check("sw3_error_clr", error, 0);
    check("sw3_starts", start_cnt - base, 3);
    check("sw3_len0", start_len[base], 1);
    check("sw3_len1", start_len[base+1], 2);
    check("sw3_len2", start_len[base+2], 3);
    check("sw3_gap01", (start_cyc[base+1] - start_cyc[base]) >= 20, 1);
    check("sw3_gap12", (start_cyc[base+2] - start_cyc[base+1]) >= 20, 1);
    check("sw3_found", found, 0);
    check("sw3_busy_end", busy, 0);

    // Stop on hit at length 2
    hit_plan[2] = 4'd2;
    base = start_cnt;
    run_sweep(5'd4, 1'b1, ok);
    check("soh_done_once", done_cnt, 1);
    check("soh_found", found, 1);
    check("soh_found_len", found_length, 2);
    check("soh_total", total_hits, 2);
    check("soh_starts", start_cnt - base, 2);

    // Full sweep, hits at 2 and 4
    hit_plan[2] = 4'd1;
    hit_plan[4] = 4'd3;
    base = start_cnt;
    run_sweep(5'd4, 1'b0, ok);
    check("full_found", found, 1);
    check("full_found_len", found_length, 2);
    check("full_total", total_hits, 4);
    check("full_starts", start_cnt - base, 4);
    check("full_len3", start_len[base+3], 4);
    for (int i = 0; i < 32; i++) hit_plan[i] = '0;

    // Abort while running length 2
    base = start_cnt;
    done_cnt = 0;
    length_limit = 5'd3;
    stop_on_hit = 1'b0;
    run = 1'b1;
    tick();
    run = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (gen_start && gen_max_length == 5'd2) seen = 1'b1;
    end
    check("abt_len2_start", seen, 1);
    repeat (3) tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    n = 0;
    seen = 1'b0;
    early_drop = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      n++;
      if (done) seen = 1'b1;
      else if (!busy) early_drop = 1'b1;
    end
    check("abt_done_seen", seen, 1);
    check("abt_busy_held", early_drop, 0);
    check("abt_done_delay", n, 8);
    check("abt_aborted", aborted, 1);
    check("abt_starts", start_cnt - base, 2);
    length_limit = 5'd2;
    run = 1'b1;
    tick();
    run = 1'b0;
    check("abt_rerun_start", gen_start, 1);
    check("abt_rerun_len", gen_max_length, 1);
    check("abt_rerun_abclr", aborted, 0);
    seen = 1'b0;
    for (int i = 0; i < 2000 && !seen; i++) begin
      tick();
      if (done) seen = 1'b1;
    end
    check("abt_rerun_done", seen, 1);
    check("abt_rerun_starts", start_cnt - base, 4);

    // Hit on the final drain cycle, then a hit in IDLE
    length_limit = 5'd1;
    run = 1'b1;
    tick();
    run = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (!gen_complete) seen = 1'b1;
    end
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      tick();
      if (gen_complete) seen = 1'b1;
    end
    check("edge_gc_rise", seen, 1);
    repeat (8) tick();
    mv_man = 1'b1; mh_man = 1'b1;
    tick();
    mv_man = 1'b0; mh_man = 1'b0;
    check("edge_busy_finish", busy, 1);
    tick();
    check("edge_done", done, 1);
    check("edge_found", found, 1);
    check("edge_found_len", found_length, 1);
    check("edge_total", total_hits, 1);
    mv_man = 1'b1; mh_man = 1'b1;
    tick();
    mv_man = 1'b0; mh_man = 1'b0;
    repeat (2) tick();
    check("idle_hit_total", total_hits, 1);
    check("idle_hit_len", found_length, 1);
    check("idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
